vdp_port: RTL and testbench
===========================

Name: vdp_port

Overview:
- CPU-side front end of the TMS9918-style VDP. Sits directly upstream of the video/VRAM block.
- Decodes Z80 accesses to the data port and the control port.
- Drives VRAM port A: address, write strobe, read strobe and write data.
- Holds VDP registers R0–R7, decodes them into the table-address, mode and colour inputs of the video block, and owns the status register and interrupt flag.
- Runs entirely in the CPU clock domain.

Parameters:
- ADDR_W, 14, VRAM address width; VRAM size is 2^ADDR_W bytes, and the address counter wraps at that size.

Ports:
- clk  in  1  CPU clock; the same clock that drives VRAM port A.
- reset  in  1  asynchronous, active-high reset.
- cpu_port  in  1  0 = data port (0x98), 1 = control port (0x99).
- cpu_wr  in  1  one-cycle write strobe.
- cpu_rd  in  1  one-cycle read strobe.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data; combinational.
- cpu_wait  out  1  high while a VRAM prefetch is in flight.
- vram_addr  out  ADDR_W  address for VRAM port A.
- vram_wr  out  1  VRAM write strobe.
- vram_rd  out  1  VRAM read strobe.
- vram_dout  out  8  VRAM write data.
- vram_din  in  8  VRAM read data; valid one cycle after vram_rd.
- vblank  in  1  one-cycle pulse at start of vertical retrace, from the video block.
- coll_in  in  1  sprite collision, from the video block.
- five_in  in  1  too-many-sprites, from the video block.
- five_num  in  5  fifth sprite number, from the video block.
- mode  out  2  display mode: 0 text, 1 graphics I, 2 graphics II, 3 multicolour.
- name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr  out  14 each  decoded table base addresses.
- video_on, vert_retrace_int, sprite_large, sprite_enlarged  out  1 each  decoded from R1.
- text_color, back_color  out  4 each  decoded from R7.
- n_int  out  1  active-low interrupt.

Behaviour:
- Reset (asynchronous): all R0–R7 = 0, address = 0, read buffer = 0, latch flag = 0, status = 0, state = IDLE. Resulting outputs: n_int = 1, cpu_wait = 0, vram_wr = 0, vram_rd = 0. A reset mid-prefetch aborts it; the buffer stays 0.
- Control write, first byte (latch flag 0): store the byte in tmp and set the latch flag.
- Control write, second byte (latch flag 1): clear the latch flag, then:
  - bit7 = 1: register write, R[cpu_din[2:0]] <= tmp.
  - bit7 = 0: address = {cpu_din[5:0], tmp}. If bit6 = 0, start a prefetch.
- Data write:
  - Drive vram_addr = address, vram_dout = cpu_din, vram_wr = 1 for one cycle, in the cycle after the strobe.
  - Read buffer <= cpu_din; address increments; latch flag clears.
- Data read:
  - cpu_dout = read buffer during the strobe.
  - Latch flag clears, then a prefetch starts.
- Prefetch FSM: IDLE -> ISSUE (vram_rd = 1, vram_addr = address) -> CAPTURE (buffer <= vram_din, address + 1) -> IDLE.
  - cpu_wait is high in ISSUE and CAPTURE.
  - Any cpu_rd/cpu_wr strobe arriving while cpu_wait is high is ignored.
- Control read (status):
  - cpu_dout = {F, 5S, C, num[4:0]}.
  - On the next cycle: F, 5S and C clear, and the latch flag clears.
- Address arithmetic: increments modulo 2^ADDR_W; 0x3FFF + 1 = 0x0000.
- Interrupt flag F:
  - Set on vblank.
  - If vblank coincides with a status read, F ends up set (set wins).
- n_int = !(F & R1[5]).
- Register decode:
  - mode = M1 ? 0 : M3 ? 2 : M2 ? 3 : 1, where M1 = R1[4], M2 = R1[3], M3 = R0[1].
  - name = R2[3:0]<<10.
  - color = R3<<6.
  - font = R4[2:0]<<11.
  - sprite attr = R5[6:0]<<7.
  - sprite pattern = R6[2:0]<<11.
  - video_on = R1[6]; vert_retrace_int = R1[5]; sprite_large = R1[1]; sprite_enlarged = R1[0].
  - text_color = R7[7:4]; back_color = R7[3:0].
- cpu_wr and cpu_rd asserted together: the write takes precedence and the read is ignored.

Optional Feature:
- Macro: VDP_COLLISION_LATCH_EN.
- Defined: 5S and C are sticky. They set on coll_in / five_in and clear only on a status read. num is captured when 5S first sets.
- Undefined: status bits 6:0 reflect coll_in, five_in and five_num live. Only F is latched.

Test Plan:
- Control write 0x00 then 0x44, data write 0xAA, data write 0xBB -> VRAM writes 0xAA@0x0400 and 0xBB@0x0401, each with one vram_wr pulse.
- Control write 0xF4 then 0x87 -> text_color = 0xF, back_color = 0x4. Then 0x02, 0x80 (R0 = 0x02) -> mode = 2.
- Control write 0xFF, 0x3F; VRAM[0x3FFF] = 0x5A; VRAM[0x0000] = 0x33 -> cpu_wait high 2 cycles, first data read = 0x5A, second = 0x33 (wrap).
- Write 0x20, 0x81 (IE on); pulse vblank -> n_int = 0. Status read returns bit7 = 1; n_int = 1 the next cycle; a second read returns bit7 = 0.
- Control write 0x12 only, then status read, then 0x34, 0x40 -> the latch was reset, so the address becomes 0x0034 with no register write. Data write goes to 0x0034.
- With VDP_COLLISION_LATCH_EN, coll_in pulsed once -> two later status reads return bit5 = 1 then 0. Without the macro -> bit5 = 0 after the pulse.

Source files
------------

// File: rtl/vdp_port.sv
// rtl/vdp_port.sv - CPU-side port of a TMS9918-style VDP: registers, VRAM access, status, interrupt
// Optional: VDP_COLLISION_LATCH_EN makes the collision / fifth-sprite status bits sticky.
module vdp_port #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_port,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_wr,
  output logic              vram_rd,
  output logic [7:0]        vram_dout,
  input  logic [7:0]        vram_din,
  input  logic              vblank,
  input  logic              coll_in,
  input  logic              five_in,
  input  logic [4:0]        five_num,
  output logic [1:0]        mode,
  output logic [13:0]       name_table_addr,
  output logic [13:0]       color_table_addr,
  output logic [13:0]       font_addr,
  output logic [13:0]       sprite_attr_addr,
  output logic [13:0]       sprite_pattern_table_addr,
  output logic              video_on,
  output logic              vert_retrace_int,
  output logic              sprite_large,
  output logic              sprite_enlarged,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color,
  output logic              n_int
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t            state;
  logic [7:0]        regs [0:7];
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        rbuf;
  logic [7:0]        tmp;
  logic [7:0]        wr_data;
  logic              latch;
  logic              flag_f;
  logic              wr_pend;
  logic [7:0]        status;

`ifdef VDP_COLLISION_LATCH_EN
  logic              s5;
  logic              sc;
  logic [4:0]        snum;
`endif

  // Strobes are dropped while a prefetch owns the VRAM port; write beats read.
  logic wr_ok, rd_ok, data_wr, ctrl_wr, data_rd, status_rd;
  assign wr_ok     = cpu_wr & ~cpu_wait;
  assign rd_ok     = cpu_rd & ~cpu_wr & ~cpu_wait;
  assign data_wr   = wr_ok & ~cpu_port;
  assign ctrl_wr   = wr_ok & cpu_port;
  assign data_rd   = rd_ok & ~cpu_port;
  assign status_rd = rd_ok & cpu_port;

  assign cpu_wait  = (state != IDLE);
  assign vram_rd   = (state == ISSUE);
  assign vram_wr   = wr_pend;
  assign vram_dout = wr_data;
  assign vram_addr = wr_pend ? wr_addr : addr;

`ifdef VDP_COLLISION_LATCH_EN
  assign status = {flag_f, s5, sc, snum};
`else
  assign status = {flag_f, five_in, coll_in, five_num};
`endif

  assign cpu_dout = cpu_port ? status : rbuf;
  assign n_int    = ~(flag_f & regs[1][5]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      addr    <= '0;
      wr_addr <= '0;
      rbuf    <= '0;
      tmp     <= '0;
      wr_data <= '0;
      latch   <= 1'b0;
      flag_f  <= 1'b0;
      wr_pend <= 1'b0;
`ifdef VDP_COLLISION_LATCH_EN
      s5      <= 1'b0;
      sc      <= 1'b0;
      snum    <= '0;
`endif
    end else begin
      wr_pend <= 1'b0;

      case (state)
        ISSUE:   state <= CAPTURE;
        CAPTURE: begin
          rbuf  <= vram_din;
          addr  <= addr + ADDR_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (data_wr) begin
        wr_pend <= 1'b1;
        wr_addr <= addr;
        wr_data <= cpu_din;
        rbuf    <= cpu_din;
        addr    <= addr + ADDR_W'(1);
        latch   <= 1'b0;
      end

      if (ctrl_wr) begin
        if (!latch) begin
          tmp   <= cpu_din;
          latch <= 1'b1;
        end else begin
          latch <= 1'b0;
          if (cpu_din[7]) begin
            regs[cpu_din[2:0]] <= tmp;
          end else begin
            addr <= ADDR_W'({cpu_din[5:0], tmp});
            if (!cpu_din[6]) state <= ISSUE;
          end
        end
      end

      if (data_rd) begin
        latch <= 1'b0;
        state <= ISSUE;
      end

      if (status_rd) begin
        latch  <= 1'b0;
        flag_f <= 1'b0;
`ifdef VDP_COLLISION_LATCH_EN
        s5     <= 1'b0;
        sc     <= 1'b0;
`endif
      end

`ifdef VDP_COLLISION_LATCH_EN
      if (coll_in) sc <= 1'b1;
      if (five_in && (!s5 || status_rd)) begin
        s5   <= 1'b1;
        snum <= five_num;
      end
`endif
      // A vblank in the same cycle as a status read must not be lost.
      if (vblank) flag_f <= 1'b1;
    end
  end

  logic m1, m2, m3;
  assign m1 = regs[1][4];
  assign m2 = regs[1][3];
  assign m3 = regs[0][1];
  assign mode = m1 ? 2'd0 : m3 ? 2'd2 : m2 ? 2'd3 : 2'd1;

  assign name_table_addr           = {regs[2][3:0], 10'b0};
  assign color_table_addr          = {regs[3], 6'b0};
  assign font_addr                 = {regs[4][2:0], 11'b0};
  assign sprite_attr_addr          = {regs[5][6:0], 7'b0};
  assign sprite_pattern_table_addr = {regs[6][2:0], 11'b0};
  assign video_on                  = regs[1][6];
  assign vert_retrace_int          = regs[1][5];
  assign sprite_large              = regs[1][1];
  assign sprite_enlarged           = regs[1][0];
  assign text_color                = regs[7][7:4];
  assign back_color                = regs[7][3:0];

  logic unused_reg_bits;
  assign unused_reg_bits = ^{regs[0][7:2], regs[0][0], regs[1][7], regs[1][2],
                             regs[2][7:4], regs[4][7:3], regs[5][7], regs[6][7:3]};

endmodule

// File: tb/tb_vdp_port.sv
// tb/tb_vdp_port.sv - randomized self-checking bench for vdp_port against a transaction-level model
// Honours VDP_COLLISION_LATCH_EN when the design is built with it.
module tb_vdp_port;
  localparam int AW    = 14;
  localparam int VSIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_port, cpu_wr, cpu_rd;
  logic [7:0]    cpu_din, cpu_dout;
  logic          cpu_wait;
  logic [AW-1:0] vram_addr;
  logic          vram_wr, vram_rd;
  logic [7:0]    vram_dout, vram_din;
  logic          vblank, coll_in, five_in;
  logic [4:0]    five_num;
  logic [1:0]    mode;
  logic [13:0]   name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr;
  logic          video_on, vert_retrace_int, sprite_large, sprite_enlarged;
  logic [3:0]    text_color, back_color;
  logic          n_int;

  always #5 clk = ~clk;

  vdp_port #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .cpu_port(cpu_port), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait), .vram_addr(vram_addr),
    .vram_wr(vram_wr), .vram_rd(vram_rd), .vram_dout(vram_dout), .vram_din(vram_din),
    .vblank(vblank), .coll_in(coll_in), .five_in(five_in), .five_num(five_num), .mode(mode),
    .name_table_addr(name_table_addr), .color_table_addr(color_table_addr), .font_addr(font_addr),
    .sprite_attr_addr(sprite_attr_addr), .sprite_pattern_table_addr(sprite_pattern_table_addr),
    .video_on(video_on), .vert_retrace_int(vert_retrace_int), .sprite_large(sprite_large),
    .sprite_enlarged(sprite_enlarged), .text_color(text_color), .back_color(back_color), .n_int(n_int)
  );

  // VRAM environment: synchronous write, read data one cycle after vram_rd
  logic [7:0] vram [VSIZE];
  always @(posedge clk) begin
    if (vram_wr) vram[vram_addr] <= vram_dout;
    if (vram_rd) vram_din <= vram[vram_addr];
  end

  // reference model state
  logic [7:0] ref_mem [VSIZE];
  int m_reg [8];
  int m_addr, m_buf, m_tmp, m_latch, m_f, m_s5, m_c, m_num;

  int checks   = 0;
  int failures = 0;
  logic [7:0] v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_addr = 0; m_buf = 0; m_tmp = 0; m_latch = 0;
    m_f = 0; m_s5 = 0; m_c = 0; m_num = 0;
  endtask

  function automatic int exp_status();
`ifdef VDP_COLLISION_LATCH_EN
    return m_f * 128 + m_s5 * 64 + m_c * 32 + m_num;
`else
    return m_f * 128 + int'(five_in) * 64 + int'(coll_in) * 32 + int'(five_num);
`endif
  endfunction

  task automatic check_decode();
    int m1, m2, m3, em;
    m1 = (m_reg[1] >> 4) & 1;
    m2 = (m_reg[1] >> 3) & 1;
    m3 = (m_reg[0] >> 1) & 1;
    em = m1 ? 0 : m3 ? 2 : m2 ? 3 : 1;
    check("mode", 32'(mode), em);
    check("name_tbl", 32'(name_table_addr), (m_reg[2] % 16) * 1024);
    check("color_tbl", 32'(color_table_addr), m_reg[3] * 64);
    check("font_tbl", 32'(font_addr), (m_reg[4] % 8) * 2048);
    check("sattr_tbl", 32'(sprite_attr_addr), (m_reg[5] % 128) * 128);
    check("spat_tbl", 32'(sprite_pattern_table_addr), (m_reg[6] % 8) * 2048);
    check("video_on", 32'(video_on), (m_reg[1] >> 6) & 1);
    check("vr_int", 32'(vert_retrace_int), (m_reg[1] >> 5) & 1);
    check("spr_large", 32'(sprite_large), (m_reg[1] >> 1) & 1);
    check("spr_enl", 32'(sprite_enlarged), m_reg[1] & 1);
    check("text_color", 32'(text_color), m_reg[7] / 16);
    check("back_color", 32'(back_color), m_reg[7] % 16);
    check("n_int", 32'(n_int), (m_f != 0 && ((m_reg[1] >> 5) & 1) != 0) ? 0 : 1);
    check("wait_idle", 32'(cpu_wait), 0);
  endtask

  task automatic strobe(input bit port, input bit wr, input bit rd, input int d);
    @(negedge clk);
    cpu_port = port; cpu_wr = wr; cpu_rd = rd; cpu_din = 8'(d);
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  // called at 1ns after the edge that accepted the initiating strobe
  task automatic prefetch(input bit inject);
    check("pf_wait1", 32'(cpu_wait), 1);
    check("pf_rd", 32'(vram_rd), 1);
    check("pf_addr", 32'(vram_addr), m_addr);
    if (inject) begin
      cpu_port = 1'b0; cpu_wr = 1'b1; cpu_din = 8'($urandom);
    end
    @(posedge clk); #1;
    cpu_wr = 1'b0;
    check("pf_wait2", 32'(cpu_wait), 1);
    check("pf_rd_off", 32'(vram_rd), 0);
    check("pf_no_wr", 32'(vram_wr), 0);
    @(posedge clk); #1;
    m_buf  = int'(ref_mem[m_addr]);
    m_addr = (m_addr + 1) % VSIZE;
    cpu_port = 1'b0;
    #1;
    check("pf_buf", 32'(cpu_dout), m_buf);
  endtask

  task automatic ctrl_write(input int b);
    bit pf;
    pf = 1'b0;
    strobe(1'b1, 1'b1, 1'b0, b);
    if (m_latch == 0) begin
      m_tmp = b; m_latch = 1;
    end else begin
      m_latch = 0;
      if (b >= 128) m_reg[b % 8] = m_tmp;
      else begin
        m_addr = ((b % 64) * 256 + m_tmp) % VSIZE;
        pf = ((b / 64) % 2) == 0;
      end
    end
    if (pf) prefetch($urandom_range(0, 3) == 0);
    check_decode();
  endtask

  task automatic data_write(input int b, input bit with_rd);
    strobe(1'b0, 1'b1, with_rd, b);
    check("dw_pulse", 32'(vram_wr), 1);
    check("dw_addr", 32'(vram_addr), m_addr);
    check("dw_data", 32'(vram_dout), b);
    ref_mem[m_addr] = 8'(b);
    m_buf = b; m_addr = (m_addr + 1) % VSIZE; m_latch = 0;
    @(posedge clk); #1;
    check("dw_once", 32'(vram_wr), 0);
    check_decode();
  endtask

  task automatic data_read(output logic [7:0] val, input bit inject);
    @(negedge clk);
    cpu_port = 1'b0; cpu_rd = 1'b1;
    #1;
    val = cpu_dout;
    check("dr_data", 32'(cpu_dout), m_buf);
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    m_latch = 0;
    prefetch(inject);
    check_decode();
  endtask

  task automatic status_read(output logic [7:0] val, input bit vb, input bit rnd);
    @(negedge clk);
    cpu_port = 1'b1; cpu_rd = 1'b1; vblank = vb;
`ifndef VDP_COLLISION_LATCH_EN
    if (rnd) begin
      coll_in = 1'($urandom); five_in = 1'($urandom); five_num = 5'($urandom);
    end
`endif
    #1;
    val = cpu_dout;
    check("status", 32'(cpu_dout), exp_status());
    @(posedge clk); #1;
    cpu_rd = 1'b0; vblank = 1'b0; coll_in = 1'b0; five_in = 1'b0;
    m_f = vb ? 1 : 0; m_latch = 0; m_s5 = 0; m_c = 0;
    check_decode();
  endtask

  task automatic vblank_pulse();
    @(negedge clk);
    vblank = 1'b1;
    @(posedge clk); #1;
    vblank = 1'b0;
    m_f = 1;
    check_decode();
  endtask

  task automatic sprite(input bit c, input bit f, input int n);
    @(negedge clk);
    coll_in = c; five_in = f; five_num = 5'(n);
    @(posedge clk); #1;
`ifdef VDP_COLLISION_LATCH_EN
    if (c) m_c = 1;
    if (f && m_s5 == 0) begin m_s5 = 1; m_num = n; end
`endif
    coll_in = 1'b0; five_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_port = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_din = 8'h00;
    vblank = 1'b0; coll_in = 1'b0; five_in = 1'b0; five_num = 5'd0;
    for (int i = 0; i < VSIZE; i++) begin
      vram[i] = 8'($urandom);
      ref_mem[i] = vram[i];
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_vram_wr", 32'(vram_wr), 0);
    check("rst_vram_rd", 32'(vram_rd), 0);
    check("rst_buf", 32'(cpu_dout), 0);
    cpu_port = 1'b1; #1;
    check("rst_status", 32'(cpu_dout), 0);
    check_decode();

    // two data writes through a loaded address
    ctrl_write(8'h00); ctrl_write(8'h44);
    data_write(8'hAA, 1'b0); data_write(8'hBB, 1'b0);
    check("tp1_mem400", 32'(vram[14'h0400]), 32'hAA);
    check("tp1_mem401", 32'(vram[14'h0401]), 32'hBB);

    // register writes and decode
    ctrl_write(8'hF4); ctrl_write(8'h87);
    check("tp2_text", 32'(text_color), 32'hF);
    check("tp2_back", 32'(back_color), 32'h4);
    ctrl_write(8'h02); ctrl_write(8'h80);
    check("tp2_mode", 32'(mode), 2);

    // prefetch and wrap at the top of VRAM
    vram[14'h3FFF] = 8'h5A; ref_mem[14'h3FFF] = 8'h5A;
    vram[14'h0000] = 8'h33; ref_mem[14'h0000] = 8'h33;
    ctrl_write(8'hFF); ctrl_write(8'h3F);
    data_read(v, 1'b0); check("tp3_first", 32'(v), 32'h5A);
    data_read(v, 1'b0); check("tp3_wrap", 32'(v), 32'h33);

    // interrupt flag
    ctrl_write(8'h20); ctrl_write(8'h81);
    vblank_pulse();
    check("tp4_nint_low", 32'(n_int), 0);
    status_read(v, 1'b0, 1'b0);
    check("tp4_f_set", 32'(v[7]), 1);
    check("tp4_nint_high", 32'(n_int), 1);
    status_read(v, 1'b0, 1'b0);
    check("tp4_f_clr", 32'(v[7]), 0);
    status_read(v, 1'b1, 1'b0);
    check("tp4_set_wins", 32'(n_int), 0);
    status_read(v, 1'b0, 1'b0);
    check("tp4_set_wins_f", 32'(v[7]), 1);

    // status read resets the byte latch
    ctrl_write(8'h12);
    status_read(v, 1'b0, 1'b0);
    ctrl_write(8'h34); ctrl_write(8'h40);
    data_write(8'h77, 1'b0);
    check("tp5_mem34", 32'(vram[14'h0034]), 32'h77);

    // collision bit
    sprite(1'b1, 1'b0, 0);
    status_read(v, 1'b0, 1'b0);
`ifdef VDP_COLLISION_LATCH_EN
    check("tp6_coll_first", 32'(v[5]), 1);
`else
    check("tp6_coll_first", 32'(v[5]), 0);
`endif
    status_read(v, 1'b0, 1'b0);
    check("tp6_coll_second", 32'(v[5]), 0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: ctrl_write($urandom_range(0, 255));
        3, 4:    data_write($urandom_range(0, 255), $urandom_range(0, 3) == 0);
        5, 6:    data_read(v, $urandom_range(0, 3) == 0);
        7:       status_read(v, $urandom_range(0, 3) == 0, 1'b1);
        8:       vblank_pulse();
        default: sprite($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 31));
      endcase
    end

    // reset in the middle of a prefetch
    status_read(v, 1'b0, 1'b0);
    ctrl_write(8'h00);
    strobe(1'b1, 1'b1, 1'b0, 8'h00);
    check("mr_in_issue", 32'(cpu_wait), 1);
    reset = 1'b1;
    cpu_port = 1'b0;
    #1;
    check("mr_wait", 32'(cpu_wait), 0);
    check("mr_rd", 32'(vram_rd), 0);
    check("mr_buf", 32'(cpu_dout), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("mr_buf_after", 32'(cpu_dout), 0);
    check_decode();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
